// File: rtl/signed_mult_fx_pipe.sv
// signed_mult_fx_pipe: pipelined signed fixed-point multiplier with valid/ready handshakes
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b valid; accepted when in_ready is high
//   in_ready   pipeline can advance this cycle
//   a, b       signed Q(WIDTH-FRAC).FRAC operands
//   out_valid  c/ovf valid; retired when out_ready is high
//   out_ready  consumer accepts c this cycle
//   c          scaled, rounded/truncated, saturated/wrapped product
//   ovf        scaled product fell outside the WIDTH-bit signed range
module signed_mult_fx_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int STAGES = 2,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH-1:0] c,
    output logic                    ovf
);
    localparam int PW = 2 * WIDTH;
    // Half-LSB bias; zero when truncating or when there are no fraction bits to drop.
    localparam logic signed [PW-1:0] RND =
        (ROUND != 0 && FRAC > 0) ? PW'(1) << (FRAC > 0 ? FRAC - 1 : 0) : '0;

    // The bias cannot overflow PW bits: |P| <= 2^(PW-2), so P + RND stays below 2^(PW-1).
    function automatic logic [WIDTH:0] scale(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] q;
        logic fits;
        q = (p + RND) >>> FRAC;
        // In range only when every bit from the result sign upward is a copy of the sign.
        fits = &q[PW-1:WIDTH-1] | ~|q[PW-1:WIDTH-1];
        return {~fits, (SAT != 0 && !fits) ? {q[PW-1], {(WIDTH-1){~q[PW-1]}}} : q[WIDTH-1:0]};
    endfunction

    logic signed [PW-1:0] prod;
    logic [STAGES-1:0] vld;

    assign prod      = PW'(a) * PW'(b);
    assign in_ready  = ~out_valid | out_ready;
    assign out_valid = vld[STAGES-1];

    // Lock-step shift: bubbles enter slot 1 whenever no transfer happens.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            vld <= '0;
        else if (in_ready)
            vld <= (vld << 1) | STAGES'(in_valid);

    if (STAGES == 1) begin : g_one
        logic [WIDTH:0] r;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)
                r <= '0;
            else if (in_ready)
                r <= scale(prod);
        assign {ovf, c} = r;
    end else begin : g_multi
        // Slot 1 holds the raw product; scaling happens on the way into slot 2.
        logic signed [PW-1:0] p;
        logic [WIDTH:0] r [2:STAGES];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                p <= '0;
                for (int i = 2; i <= STAGES; i++)
                    r[i] <= '0;
            end else if (in_ready) begin
                p    <= prod;
                r[2] <= scale(p);
                for (int i = 3; i <= STAGES; i++)
                    r[i] <= r[i-1];
            end
        assign {ovf, c} = r[STAGES];
    end
endmodule

// File: tb/tb_signed_mult_fx_pipe.sv
// tb_signed_mult_fx_pipe: directed and randomized checks for signed_mult_fx_pipe
module tb_signed_mult_fx_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv16 = 1'b0, ordy16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir_d, ov_d, ovf_d, ir_t, ov_t, ovf_t;
    logic [15:0] c_d, c_t;
    logic        iv8 = 1'b0, ordy8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, c8;
    logic        ir8, ov8, ovf8;
    int n_chk = 0, n_fail = 0;

    signed_mult_fx_pipe u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir_d), .a(a16), .b(b16),
        .out_valid(ov_d), .out_ready(ordy16), .c(c_d), .ovf(ovf_d)
    );
    signed_mult_fx_pipe #(.ROUND(0), .SAT(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir_t), .a(a16), .b(b16),
        .out_valid(ov_t), .out_ready(ordy16), .c(c_t), .ovf(ovf_t)
    );
    signed_mult_fx_pipe #(.WIDTH(8), .FRAC(4), .STAGES(3)) u_sw (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(ordy8), .c(c8), .ovf(ovf8)
    );

    localparam int NV = 10;
    localparam logic [15:0] VA [NV] = '{16'h0400, 16'hFC00, 16'hFC00, 16'h0300, 16'h7F00,
                                        16'h8000, 16'h0001, 16'hFFFF, 16'h8000, 16'h8000};
    localparam logic [15:0] VB [NV] = '{16'h0300, 16'h0300, 16'hFE00, 16'hFE00, 16'h0200,
                                        16'h8000, 16'h0080, 16'h0080, 16'h0100, 16'h0200};
    // Round-half-up + saturate
    localparam logic [15:0] ED_C [NV] = '{16'h0C00, 16'hF400, 16'h0800, 16'hFA00, 16'h7FFF,
                                          16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h8000};
    localparam logic        ED_O [NV] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    // Truncate + wrap
    localparam logic [15:0] ET_C [NV] = '{16'h0C00, 16'hF400, 16'h0800, 16'hFA00, 16'hFE00,
                                          16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000};
    localparam logic        ET_O [NV] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Streams table entries first..first+n-1 through both 16-bit DUTs; called at a negedge.
    task automatic stream16(input int first, input int n, input int stall_at, input int stall_len);
        int sent, got, cyc;
        int acc [NV];
        logic [15:0] held;
        sent = 0;
        got = 0;
        cyc = 0;
        held = '0;
        while (got < n && cyc < 100) begin
            ordy16 = !(cyc >= stall_at && cyc < stall_at + stall_len);
            iv16 = sent < n;
            if (sent < n) begin
                a16 = VA[first + sent];
                b16 = VB[first + sent];
            end
            #1;
            if (ov_d && !ordy16) begin
                check("stall_in_ready", ir_d, 0);
                if (cyc > stall_at) check("stall_hold_c", c_d, held);
                held = c_d;
            end
            if (ov_d && ordy16) begin
                check("c_round_sat", c_d, ED_C[first + got]);
                check("ovf_round_sat", ovf_d, ED_O[first + got]);
                check("valid_trunc_wrap", ov_t, 1);
                check("c_trunc_wrap", c_t, ET_C[first + got]);
                check("ovf_trunc_wrap", ovf_t, ET_O[first + got]);
                if (stall_len == 0) check("latency16", cyc - acc[got], 2);
                got++;
            end
            if (iv16 && ir_d) begin
                acc[sent] = cyc;
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        check("stream16_count", got, n);
        iv16 = 1'b0;
        ordy16 = 1'b1;
        #1 check("stream16_no_extra", ov_d, 0);
        @(negedge clk);
    endtask

    // Random operands through the WIDTH=8, FRAC=4, STAGES=3 instance against an integer model.
    task automatic sweep(input int n, input bit rand_rdy);
        logic [8:0] q_exp [$];
        int q_cyc [$];
        int sent, got, cyc, p, q, lat;
        logic acc;
        logic [8:0] e;
        sent = 0;
        got = 0;
        cyc = 0;
        acc = 1'b1;
        while (got < n && cyc < 20 * n) begin
            ordy8 = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (acc || !iv8) begin
                iv8 = (sent < n) && ($urandom_range(0, 4) != 0);
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            acc = 1'b0;
            #1;
            if (ov8 && ordy8) begin
                e = q_exp.pop_front();
                lat = cyc - q_cyc.pop_front();
                check("sweep_c", c8, e[7:0]);
                check("sweep_ovf", ovf8, e[8]);
                if (!rand_rdy) check("sweep_latency", lat, 3);
                got++;
            end
            if (iv8 && ir8) begin
                p = int'($signed(a8)) * int'($signed(b8));
                q = (p + 8) >>> 4;
                e = q > 127 ? 9'h17F : q < -128 ? 9'h180 : {1'b0, q[7:0]};
                q_exp.push_back(e);
                q_cyc.push_back(cyc);
                sent++;
                acc = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check("sweep_count", got, n);
        iv8 = 1'b0;
        ordy8 = 1'b1;
    endtask

    initial begin
        #1;
        check("rst_out_valid", ov_d, 0);
        check("rst_c", c_d, 0);
        check("rst_ovf", ovf_d, 0);
        check("rst_in_ready", ir_d, 1);
        check("rst_sweep_valid", ov8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stream16(0, 1, 99, 0);
        stream16(1, 3, 99, 0);
        stream16(4, 6, 99, 0);
        stream16(0, 6, 3, 3);
        // Reset with two items in flight: one stalled at the output, one in slot 1.
        iv16 = 1'b1;
        a16 = VA[0];
        b16 = VB[0];
        @(negedge clk);
        a16 = VA[1];
        b16 = VB[1];
        @(negedge clk);
        iv16 = 1'b0;
        ordy16 = 1'b0;
        #1 check("pre_rst_valid", ov_d, 1);
        check("pre_rst_c", c_d, 16'h0C00);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", ov_d, 0);
        check("async_rst_c", c_d, 0);
        check("async_rst_ovf", ovf_d, 0);
        check("async_rst_in_ready", ir_d, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ordy16 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1 check("post_rst_no_stale", ov_d, 0);
        end
        @(negedge clk);
        sweep(600, 1'b0);
        sweep(400, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1);
    end
endmodule

// File: doc/signed_mult_fx_pipe.md
# signed_mult_fx_pipe

Parametrised, pipelined signed fixed-point multiplier: the clocked successor to the 16-bit combinational signed multiplier. It computes C = A×B in Q(WIDTH−FRAC).FRAC format with selectable round/truncate and saturate/wrap, and flags overflow. Operands enter and results leave through valid/ready handshakes, so the block drops into streaming datapaths (filters, MAC chains) with back-pressure.

## Interface
- WIDTH, 16: operand and result width, signed two's complement (≥4).
- FRAC, 8: fractional bits in A, B and C (0 ≤ FRAC < WIDTH).
- STAGES, 2: pipeline depth in cycles (≥1).
- ROUND, 1: 1 = round half up (toward +∞); 0 = truncate (floor).
- SAT, 1: 1 = clamp on overflow; 0 = wrap (keep low WIDTH bits).
- CLK  in  1  clock, rising edge; the block's only clock.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  A/B valid.
- IN_READY  out  1  block accepts A/B this cycle.
- A  in  WIDTH  signed multiplicand.
- B  in  WIDTH  signed multiplier.
- OUT_VALID  out  1  C/OVF valid.
- OUT_READY  in  1  consumer accepts C this cycle.
- C  out  WIDTH  signed result.
- OVF  out  1  result exceeded the WIDTH-bit signed range (qualified by OUT_VALID).

## Operation
- Full product P = A×B, 2·WIDTH bits signed, exact.
- Scaling: ROUND=1 → Q = (P + 2^(FRAC−1)) >>> FRAC; ROUND=0 → Q = P >>> FRAC (arithmetic shift). FRAC=0 → Q = P, no rounding term.
- Range check on Q against [−2^(WIDTH−1), 2^(WIDTH−1)−1]; OVF=1 if outside.
- SAT=1: out-of-range Q clamps to 2^(WIDTH−1)−1 (0x7FFF) or −2^(WIDTH−1) (0x8000) by sign. SAT=0: C = Q[WIDTH−1:0]. OVF is reported in both modes.
- The product is registered at stage 1; rounding, range check and clamp go in later stages (STAGES=1 does all of it before the single register).
- Pipeline is a lock-step shift register of STAGES slots, each with a valid bit. Advance = ~OUT_VALID | OUT_READY. When advance=0 every slot holds.
- IN_READY = advance (a combinational path from OUT_READY is permitted). A transfer happens when IN_VALID & IN_READY; otherwise a bubble (valid=0) enters slot 1 on advance.
- Bubbles are not collapsed: throughput is 1 result/cycle when OUT_READY stays high.
- OUT_VALID = valid bit of the last slot. C/OVF stay stable while OUT_VALID & ~OUT_READY.

## Timing
- Reset (RST_N low, asynchronous): all slot valid bits 0, all data registers 0; OUT_VALID=0, C=0, OVF=0. IN_READY=1 while RST_N is low and after release.
- Reset mid-operation discards every in-flight item. The first acceptance after release is on the first rising edge with RST_N high.
- Latency: an operand accepted at edge n appears with OUT_VALID=1 after edge n+STAGES−1, i.e. during the cycle following STAGES edges including n. Under continuous ready this is exactly STAGES cycles from IN_VALID to OUT_VALID.
- Stall: each cycle with OUT_VALID & ~OUT_READY adds one cycle of latency to all in-flight items. Items are never dropped or duplicated.
- Simultaneous OUT_READY=1 and new input in the same cycle (full pipeline): output retires and input is accepted on the same edge.
- IN_VALID with IN_READY=0: A/B are ignored. The source holds them.

## Test plan
- Defaults, OUT_READY=1: A=0x0400, B=0x0300 → C=0x0C00, OVF=0, exactly 2 cycles later. Then A=0xFC00,B=0x0300 → 0xF400; A=0xFC00,B=0xFE00 → 0x0800; A=0x0300,B=0xFE00 → 0xFA00, back-to-back, one per cycle.
- Overflow: A=0x7F00,B=0x0200 → C=0x7FFF, OVF=1. A=0x8000,B=0x8000 → C=0x7FFF, OVF=1. With SAT=0 the first gives C=0xFE00, OVF=1.
- Rounding: A=0x0001,B=0x0080 → ROUND=1: 0x0001; ROUND=0: 0x0000. A=0xFFFF,B=0x0080 → ROUND=1: 0x0000; ROUND=0: 0xFFFF.
- Back-pressure: stream 6 operand pairs and hold OUT_READY=0 for 3 cycles mid-stream. C is stable while stalled, IN_READY=0 while stalled, all 6 results arrive in order with none lost.
- Reset mid-flight: assert RST_N=0 asynchronously between edges with 2 items in flight. OUT_VALID, C and OVF go to 0 immediately, and no stale result appears after release.
- Parameter sweep: WIDTH=8, FRAC=4, STAGES=3 with 1000 random operands compared against a reference model. Latency is 3 cycles.
